// File: rtl/covox_fifo_pkg.sv
// Shared sound-stage constants: default sizes, reset divisor and sequencer state encoding.
package covox_fifo_pkg;

  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_DIV_W      = 12;
  // 28 MHz / (635 + 1) ~= 44.0 kHz
  localparam int DIV_RST        = 635;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } covox_st_e;

endpackage

// File: rtl/covox_fifo_mem.sv
// Sample FIFO storage and pointers; synchronous write, registered read on pop.
module covox_fifo_mem
  import covox_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [7:0]            rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= 8'h00;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers wrap naturally at the power-of-two depth.
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        rdata_q  <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + (DEPTH_LOG2+1)'(1);
        2'b01:   level_q <= level_q - (DEPTH_LOG2+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign level = level_q;

endmodule

// File: rtl/covox_fifo.sv
// Covox sample FIFO: CPU pushes bytes, a programmable divisor paces pops to the sound stage.
module covox_fifo
  import covox_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic                smp_wr,
  input  logic                div_lo_wr,
  input  logic                div_hi_wr,
  input  logic                en,
  input  logic                flush,
  output logic [7:0]          dout,
  output logic                covox_wr,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty,
  output logic                underrun,
  output logic                overflow
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  covox_st_e        st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic             tick, push, pop;
  logic             covox_wr_q, underrun_q, underrun_d, overflow_q, overflow_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    tick  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (en) begin
          st_d  = ST_COUNT;
          cnt_d = div_q;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          st_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          tick  = 1'b1;
          cnt_d = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
    endcase
  end

  // Divisor only reaches the counter at reload, so a running period is never cut short.
  always_comb begin
    div_d = div_q;
    if (div_lo_wr) div_d[7:0]       = din;
    if (div_hi_wr) div_d[DIV_W-1:8] = din[DIV_W-9:0];
  end

  assign full  = (level == DEPTH_CNT);
  assign empty = (level == '0);

  // Flush wins over both ends; a pop frees the slot a same-cycle push needs when full.
  assign pop  = tick && !empty && !flush;
  assign push = smp_wr && !flush && (!full || pop);

  assign underrun_d = !flush && (underrun_q || (tick && empty));
  assign overflow_d = !flush && (overflow_q || (smp_wr && full && !pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(DIV_RST);
      covox_wr_q <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      covox_wr_q <= pop;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  covox_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (dout),
    .level (level)
  );

  assign covox_wr = covox_wr_q;
  assign underrun = underrun_q;
  assign overflow = overflow_q;

endmodule

// File: doc/covox_fifo.md
COVOX_FIFO -- requirements
Module: covox_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth 2**DEPTH_LOG2 = 16 entries.
REQ-002 SHALL have parameter DIV_W, default 12, width of the sample-rate divisor.
REQ-003 SHALL have port clk  in  1  system clock, 28 MHz; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din  in  8  CPU write data, shared by all write strobes.
REQ-006 SHALL have port smp_wr  in  1  one-cycle strobe; push din into the FIFO.
REQ-007 SHALL have port div_lo_wr  in  1  one-cycle strobe; div[7:0] <= din.
REQ-008 SHALL have port div_hi_wr  in  1  one-cycle strobe; div[DIV_W-1:8] <= din[DIV_W-9:0].
REQ-009 SHALL have port en  in  1  level; playback enable.
REQ-010 SHALL have port flush  in  1  one-cycle strobe; empty the FIFO, clear both sticky flags.
REQ-011 SHALL have port dout  out  8  sample to the sound stage; held between pops.
REQ-012 SHALL have port covox_wr  out  1  one-cycle strobe; dout is valid while it is high.
REQ-013 SHALL have port level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..16.
REQ-014 SHALL have ports full, empty  out  1  each; combinational from level.
REQ-015 SHALL have ports underrun, overflow  out  1  each; sticky error flags.

Function
REQ-016 SHALL run a down-counter cnt[DIV_W-1:0] in state COUNT; when cnt==0 it SHALL reload div and assert internal tick for one cycle; sample period = div+1 clocks.
REQ-017 SHALL implement states IDLE and COUNT: IDLE->COUNT when en=1, loading cnt<=div; COUNT->IDLE when en=0; cnt frozen in IDLE.
REQ-018 SHALL, on tick with level>0, pop the FIFO head into dout and assert covox_wr in the next cycle (latency 1 clock from tick).
REQ-019 SHALL, on tick with level==0, set underrun, leave dout unchanged, and keep covox_wr low.
REQ-020 SHALL, on smp_wr with level==16 and no same-cycle pop, drop the byte and set overflow.
REQ-021 SHALL accept smp_wr when full if a pop occurs in the same cycle; level stays 16.
REQ-022 SHALL, on simultaneous smp_wr and tick with level==0, store the byte (level becomes 1) and set underrun; the byte is not bypassed to dout.
REQ-023 SHALL wrap read and write pointers modulo 16 with no bubble.
REQ-024 SHALL give flush priority over smp_wr and pop in the same cycle: level becomes 0, flags clear, and covox_wr stays low next cycle.
REQ-025 SHALL take effect for a divisor write at the next reload only; an active count is not disturbed.
REQ-026 SHALL keep underrun/overflow set until flush or reset.
REQ-027 SHALL treat div==0 as a tick every clock (sample rate = clk).

Reset
REQ-028 SHALL, on rst, asynchronously force the following: state=IDLE; cnt=0; div=635 (44.0 kHz at 28 MHz); pointers=0; level=0; dout=8'h00; covox_wr=0; underrun=0; overflow=0.
REQ-029 SHALL, on reset mid-playback, discard FIFO contents and leave no partial covox_wr pulse.
REQ-030 SHALL NOT reset FIFO storage RAM.

Structure
REQ-031 SHALL take DIV_W, DEPTH_LOG2, the reset divisor constant and state encodings from the shared sound package.
REQ-032 SHALL place the FIFO storage and pointers in one sub-module, covox_fifo_mem (sync write, registered read at pop).
REQ-033 SHALL connect dout/covox_wr directly to the sound stage's din/covox_wr with no extra register.

Verification
REQ-034 SHALL pass this check: div=3, en=1, push 8'h10,8'h20,8'h30 -> covox_wr pulses every 4 clocks, dout 10,20,30, then underrun=1 at the 4th tick.
REQ-035 SHALL pass this check: push 17 bytes with en=0 -> level=16, full=1, overflow=1, 17th byte absent from the played sequence.
REQ-036 SHALL pass this check: full FIFO, smp_wr coincident with tick -> level stays 16, overflow=0, new byte played last.
REQ-037 SHALL pass this check: empty FIFO, smp_wr coincident with tick -> underrun=1, no covox_wr, byte output at the following tick.
REQ-038 SHALL pass this check: playing with level=5, assert flush -> level=0, flags 0, no further covox_wr; then rst mid-count -> dout=00, div=635.
REQ-039 SHALL pass this check: write div=1000 while counting with div=3 -> current period stays 4 clocks, next period is 1001 clocks.
